// File: rtl/pulse_meter.sv
// Pulse-train meter: measures period and high time of a synchronized input in
// clock cycles and hands each pair out over valid/ready, with timeout/overrun flags.
module pulse_meter #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 1_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_100MHz,
  input  logic             RSTN,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             timeout,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q, rise_q, fall_q;
  logic [CNT_W-1:0]       cnt_q, high_q, period_q, hi_out_q;
  logic                   valid_q, timeout_q, overrun_q;

  logic                   sync_s;
  logic [CNT_W-1:0]       cnt_d;
  logic                   capture_d;

  assign sync_s    = sync_q[SYNC_STAGES-1];
  assign cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign capture_d = (state_q == MEASURE) && rise_q;

  // Strobes are registered so both edges see identical latency.
  always_ff @(posedge clk_100MHz or negedge RSTN) begin
    if (!RSTN) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      edge_q <= sync_s;
      rise_q <= sync_s & ~edge_q;
      fall_q <= ~sync_s & edge_q;
    end
  end

  always_ff @(posedge clk_100MHz or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      high_q    <= '0;
      period_q  <= '0;
      hi_out_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (!enable) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= ARM;
          cnt_q   <= '0;
        end
        ARM: begin
          if (rise_q) begin
            state_q <= MEASURE;
            cnt_q   <= CNT_ONE;
            high_q  <= '0;
          end else if (cnt_q == TO_VAL) begin
            timeout_q <= 1'b1;
            cnt_q     <= CNT_ONE;
            high_q    <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        MEASURE: begin
          if (rise_q) begin
            cnt_q  <= CNT_ONE;
            high_q <= '0;
          end else if (cnt_q == TO_VAL) begin
            state_q   <= ARM;
            timeout_q <= 1'b1;
            cnt_q     <= CNT_ONE;
            high_q    <= '0;
          end else begin
            cnt_q <= cnt_d;
            if (fall_q) high_q <= cnt_q;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase

      // A full output register that is not being drained drops the new pair.
      if (capture_d) begin
        if (!valid_q || meas_ready) begin
          period_q <= cnt_q;
          hi_out_q <= high_q;
          valid_q  <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && meas_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign meas_period = period_q;
  assign meas_high   = hi_out_q;
  assign meas_valid  = valid_q;
  assign timeout     = timeout_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Self-checking bench for pulse_meter: random pulse trains against a queue of
// expected (period, high) pairs derived from the drive pattern itself.
`timescale 1ns/1ps
module tb_pulse_meter;
  localparam int CNT_W = 32;
  localparam int TO    = 1000;
  localparam int SS    = 2;

  logic clk_100MHz = 1'b0;
  logic RSTN = 1'b0, sig_in = 1'b0, enable = 1'b0, meas_ready = 1'b0;
  logic [CNT_W-1:0] meas_period, meas_high, s_period, s_high;
  logic meas_valid, timeout, overrun, s_valid, s_timeout, s_overrun;

  int vectors = 0, miscompares = 0;
  int cyc = 0;

  typedef struct {int unsigned per; int unsigned hi; int at;} meas_t;
  meas_t exp_q[$];

  always #5 clk_100MHz = ~clk_100MHz;
  always @(posedge clk_100MHz) cyc <= cyc + 1;

  pulse_meter #(.CNT_W(CNT_W), .TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
    .clk_100MHz(clk_100MHz), .RSTN(RSTN), .sig_in(sig_in), .enable(enable),
    .meas_period(meas_period), .meas_high(meas_high), .meas_valid(meas_valid),
    .meas_ready(meas_ready), .timeout(timeout), .overrun(overrun));

  // Long-timeout instance for the 40 kHz train (period exceeds TO).
  pulse_meter #(.CNT_W(CNT_W), .TIMEOUT(4000), .SYNC_STAGES(SS)) dut_slow (
    .clk_100MHz(clk_100MHz), .RSTN(RSTN), .sig_in(sig_in), .enable(enable),
    .meas_period(s_period), .meas_high(s_high), .meas_valid(s_valid),
    .meas_ready(meas_ready), .timeout(s_timeout), .overrun(s_overrun));

  task automatic restart();
    @(negedge clk_100MHz);
    enable = 1'b0; meas_ready = 1'b0; sig_in = 1'b0;
    @(negedge clk_100MHz);
    enable = 1'b1;
    repeat (4) @(negedge clk_100MHz);
    exp_q.delete();
  endtask

  // Reference model: each rise after the first yields the previous hi+lo and hi.
  task automatic drive_train(input int n, input int hmin, input int hmax,
                             input int lmin, input int lmax);
    int hi, lo, phi, plo;
    phi = 0; plo = 0;
    for (int k = 0; k < n; k++) begin
      hi = int'($urandom_range(hmax, hmin));
      lo = int'($urandom_range(lmax, lmin));
      sig_in = 1'b1;
      if (k > 0) exp_q.push_back('{per: phi + plo, hi: phi, at: cyc});
      repeat (hi) @(negedge clk_100MHz);
      sig_in = 1'b0;
      repeat (lo) @(negedge clk_100MHz);
      phi = hi; plo = lo;
    end
  endtask

  task automatic test_reset();
    #23;
    vectors++; if (meas_period !== 0) begin miscompares++; $display("FAIL reset_period: got %0d want 0", meas_period); end
    vectors++; if (meas_high !== 0) begin miscompares++; $display("FAIL reset_high: got %0d want 0", meas_high); end
    vectors++; if (meas_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", meas_valid); end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    @(negedge clk_100MHz);
    RSTN = 1'b1;
    enable = 1'b1;
    repeat (5) @(negedge clk_100MHz);
    vectors++; if (meas_valid !== 1'b0 || timeout !== 1'b0) begin
      miscompares++; $display("FAIL idle_after_reset: valid %b timeout %b want 0 0", meas_valid, timeout);
    end
  endtask

  task automatic test_ch_pattern();
    int got, budget, last;
    meas_t e;
    restart();
    meas_ready = 1'b1;
    fork
      drive_train(12, 1, 1, 4, 4);
      begin
        got = 0; budget = 200; last = -1;
        while (got < 11 && budget > 0) begin
          @(negedge clk_100MHz); budget--;
          if (meas_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++; $display("FAIL ch_unexpected_valid: period %0d high %0d with nothing expected", meas_period, meas_high);
            end else begin
              e = exp_q.pop_front();
              if (meas_period !== e.per || meas_high !== e.hi) begin
                miscompares++; $display("FAIL ch_data: got %0d/%0d want %0d/%0d", meas_period, meas_high, e.per, e.hi);
              end
              vectors++;
              if (cyc - e.at != SS + 2) begin
                miscompares++; $display("FAIL ch_latency: got %0d want %0d", cyc - e.at, SS + 2);
              end
            end
            if (last >= 0) begin
              vectors++;
              if (cyc - last != 5) begin miscompares++; $display("FAIL ch_spacing: got %0d want 5", cyc - last); end
            end
            last = cyc; got++;
          end
        end
        vectors++; if (got != 11) begin miscompares++; $display("FAIL ch_count: got %0d want 11", got); end
      end
    join
  endtask

  task automatic test_random();
    int got, budget;
    meas_t e;
    restart();
    meas_ready = 1'b1;
    fork
      drive_train(20, 2, 40, 2, 40);
      begin
        got = 0; budget = 1700;
        while (got < 19 && budget > 0) begin
          @(negedge clk_100MHz); budget--;
          if (meas_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++; $display("FAIL rnd_unexpected_valid: period %0d high %0d", meas_period, meas_high);
            end else begin
              e = exp_q.pop_front();
              if (meas_period !== e.per || meas_high !== e.hi) begin
                miscompares++; $display("FAIL rnd_data: got %0d/%0d want %0d/%0d", meas_period, meas_high, e.per, e.hi);
              end
            end
            got++;
          end
        end
        vectors++; if (got != 19) begin miscompares++; $display("FAIL rnd_count: got %0d want 19", got); end
      end
    join
  endtask

  task automatic test_async_40k();
    int got, budget;
    restart();
    meas_ready = 1'b1;
    fork
      begin
        @(posedge clk_100MHz);
        #(1 + ($urandom % 8));
        repeat (5) begin
          sig_in = 1'b1; #12500;
          sig_in = 1'b0; #12500;
        end
      end
      begin
        got = 0; budget = 11500;
        while (got < 4 && budget > 0) begin
          @(negedge clk_100MHz); budget--;
          if (s_valid) begin
            vectors++;
            if (s_period < 2499 || s_period > 2501) begin miscompares++; $display("FAIL async_period: got %0d want 2500+-1", s_period); end
            vectors++;
            if (s_high < 1249 || s_high > 1251) begin miscompares++; $display("FAIL async_high: got %0d want 1250+-1", s_high); end
            got++;
          end
        end
        vectors++; if (got != 4) begin miscompares++; $display("FAIL async_count: got %0d want 4", got); end
      end
    join
  endtask

  task automatic test_overrun();
    int h[5], l[5];
    restart();
    for (int k = 0; k < 5; k++) begin h[k] = int'($urandom_range(20, 3)); l[k] = int'($urandom_range(20, 3)); end
    l[3] = 40;
    for (int k = 0; k < 4; k++) begin
      sig_in = 1'b1; repeat (h[k]) @(negedge clk_100MHz);
      sig_in = 1'b0; if (k < 3) repeat (l[k]) @(negedge clk_100MHz);
      if (k == 1) begin
        vectors++; if (overrun !== 1'b0 || meas_valid !== 1'b1) begin
          miscompares++; $display("FAIL ovr_first_capture: valid %b overrun %b want 1 0", meas_valid, overrun);
        end
      end
    end
    repeat (10) @(negedge clk_100MHz);
    vectors++; if (meas_valid !== 1'b1 || overrun !== 1'b1) begin
      miscompares++; $display("FAIL ovr_flags: valid %b overrun %b want 1 1", meas_valid, overrun);
    end
    vectors++; if (meas_period !== h[0] + l[0] || meas_high !== h[0]) begin
      miscompares++; $display("FAIL ovr_held: got %0d/%0d want %0d/%0d", meas_period, meas_high, h[0] + l[0], h[0]);
    end
    meas_ready = 1'b1;
    @(negedge clk_100MHz);
    meas_ready = 1'b0;
    vectors++; if (meas_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_drain: valid %b want 0", meas_valid); end
    repeat (l[3] - 11) @(negedge clk_100MHz);
    sig_in = 1'b1;
    repeat (5) @(negedge clk_100MHz);
    vectors++; if (meas_valid !== 1'b1 || meas_period !== h[3] + l[3] || meas_high !== h[3]) begin
      miscompares++; $display("FAIL ovr_reload: valid %b got %0d/%0d want 1 %0d/%0d", meas_valid, meas_period, meas_high, h[3] + l[3], h[3]);
    end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    sig_in = 1'b0;
    repeat (10) @(negedge clk_100MHz);
  endtask

  task automatic test_timeout();
    int c;
    bit seen;
    restart();
    meas_ready = 1'b1;
    sig_in = 1'b1; repeat (5) @(negedge clk_100MHz);
    sig_in = 1'b0; repeat (5) @(negedge clk_100MHz);
    sig_in = 1'b1; c = cyc;
    repeat (4) @(negedge clk_100MHz);
    vectors++; if (meas_valid !== 1'b1 || meas_period !== 10 || meas_high !== 5) begin
      miscompares++; $display("FAIL to_meas: valid %b got %0d/%0d want 1 10/5", meas_valid, meas_period, meas_high);
    end
    @(negedge clk_100MHz);
    sig_in = 1'b0;
    seen = 1'b0;
    while (cyc < c + TO + 3) begin
      @(negedge clk_100MHz);
      if (meas_valid) seen = 1'b1;
    end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL to_early: timeout %b want 0", timeout); end
    vectors++; if (seen) begin miscompares++; $display("FAIL to_spurious_valid: got 1 want 0"); end
    @(negedge clk_100MHz);
    vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL to_set: timeout %b want 1", timeout); end
    sig_in = 1'b1; repeat (8) @(negedge clk_100MHz);
    sig_in = 1'b0; repeat (8) @(negedge clk_100MHz);
    vectors++; if (meas_valid !== 1'b0) begin miscompares++; $display("FAIL to_one_rise: valid %b want 0", meas_valid); end
    sig_in = 1'b1; repeat (4) @(negedge clk_100MHz);
    vectors++; if (meas_valid !== 1'b1 || meas_period !== 16 || meas_high !== 8 || timeout !== 1'b1) begin
      miscompares++; $display("FAIL to_resume: valid %b got %0d/%0d to %b want 1 16/8 1", meas_valid, meas_period, meas_high, timeout);
    end
    sig_in = 1'b0;
    repeat (10) @(negedge clk_100MHz);
  endtask

  task automatic test_reset_mid();
    restart();
    sig_in = 1'b1; repeat (5) @(negedge clk_100MHz);
    sig_in = 1'b0; repeat (5) @(negedge clk_100MHz);
    sig_in = 1'b1; repeat (6) @(negedge clk_100MHz);
    sig_in = 1'b0; repeat (3) @(negedge clk_100MHz);
    vectors++; if (meas_valid !== 1'b1 || meas_period !== 10) begin
      miscompares++; $display("FAIL rst_pre: valid %b period %0d want 1 10", meas_valid, meas_period);
    end
    #2 RSTN = 1'b0;
    #1;
    vectors++; if (meas_period !== 0 || meas_high !== 0 || meas_valid !== 1'b0 || timeout !== 1'b0 || overrun !== 1'b0) begin
      miscompares++; $display("FAIL rst_async: got %0d/%0d v%b t%b o%b want all 0", meas_period, meas_high, meas_valid, timeout, overrun);
    end
    @(negedge clk_100MHz);
    RSTN = 1'b1; meas_ready = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    sig_in = 1'b1; repeat (6) @(negedge clk_100MHz);
    sig_in = 1'b0; repeat (6) @(negedge clk_100MHz);
    vectors++; if (meas_valid !== 1'b0) begin miscompares++; $display("FAIL rst_one_rise: valid %b want 0", meas_valid); end
    sig_in = 1'b1; repeat (4) @(negedge clk_100MHz);
    vectors++; if (meas_valid !== 1'b1 || meas_period !== 12 || meas_high !== 6) begin
      miscompares++; $display("FAIL rst_resume: valid %b got %0d/%0d want 1 12/6", meas_valid, meas_period, meas_high);
    end
    sig_in = 1'b0;
    repeat (10) @(negedge clk_100MHz);
  endtask

  task automatic test_enable_drop();
    int h[3], l[3];
    restart();
    for (int k = 0; k < 3; k++) begin h[k] = int'($urandom_range(10, 3)); l[k] = int'($urandom_range(10, 3)); end
    repeat (TO + 20) @(negedge clk_100MHz);
    vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL en_timeout: got %b want 1", timeout); end
    for (int k = 0; k < 3; k++) begin
      sig_in = 1'b1; repeat (h[k]) @(negedge clk_100MHz);
      sig_in = 1'b0; repeat (l[k]) @(negedge clk_100MHz);
    end
    repeat (10) @(negedge clk_100MHz);
    vectors++; if (meas_valid !== 1'b1 || timeout !== 1'b1 || overrun !== 1'b1) begin
      miscompares++; $display("FAIL en_pre_flags: v%b t%b o%b want 1 1 1", meas_valid, timeout, overrun);
    end
    enable = 1'b0;
    @(negedge clk_100MHz);
    vectors++; if (meas_valid !== 1'b0 || timeout !== 1'b0 || overrun !== 1'b0) begin
      miscompares++; $display("FAIL en_clear: v%b t%b o%b want 0 0 0", meas_valid, timeout, overrun);
    end
    vectors++; if (meas_period !== h[0] + l[0] || meas_high !== h[0]) begin
      miscompares++; $display("FAIL en_hold: got %0d/%0d want %0d/%0d", meas_period, meas_high, h[0] + l[0], h[0]);
    end
    enable = 1'b1; meas_ready = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    sig_in = 1'b1; repeat (7) @(negedge clk_100MHz);
    sig_in = 1'b0; repeat (9) @(negedge clk_100MHz);
    sig_in = 1'b1; repeat (4) @(negedge clk_100MHz);
    vectors++; if (meas_valid !== 1'b1 || meas_period !== 16 || meas_high !== 7) begin
      miscompares++; $display("FAIL en_resume: valid %b got %0d/%0d want 1 16/7", meas_valid, meas_period, meas_high);
    end
    sig_in = 1'b0;
    repeat (10) @(negedge clk_100MHz);
  endtask

  initial begin
    test_reset();
    test_ch_pattern();
    test_random();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_enable_drop();
    test_async_40k();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pulse_meter.md
# pulse_meter

Measures the period and high time of one incoming channel pulse train in clk_100MHz cycles and hands each measurement out over a valid/ready interface. It sits on the receive side of the transducer channel outputs: it reads back a CH line, or an external sync/echo line, to check drive frequency and duty. It also flags a missing signal (timeout) and dropped measurements (overrun).

## Interface
- CNT_W, 32: width of the cycle counter and measurement outputs.
- TIMEOUT, 1_000_000: cycles without a rising edge before timeout (10 ms at 100 MHz); must be ≥ 2 and < 2^CNT_W.
- SYNC_STAGES, 2: synchronizer flops on sig_in; must be ≥ 2.

- clk_100MHz  input  1  system clock, 100 MHz.
- RSTN  input  1  reset, asynchronous, active-low.
- sig_in  input  1  asynchronous pulse train to measure.
- enable  input  1  1 = measure; 0 = force IDLE and clear flags.
- meas_period  output  CNT_W  cycles between two consecutive rising edges.
- meas_high  output  CNT_W  cycles from a rising edge to the following falling edge.
- meas_valid  output  1  measurement pair is valid.
- meas_ready  input  1  consumer accepts when meas_valid && meas_ready.
- timeout  output  1  sticky: no rising edge for TIMEOUT cycles.
- overrun  output  1  sticky: a new measurement was dropped because the output was still full.

## Operation
- sig_in passes through SYNC_STAGES flops and then one edge register. rise/fall are single-cycle strobes on the synchronized signal.
- A single counter cnt:
  - loads 1 in the cycle after a rise strobe;
  - otherwise increments each cycle;
  - saturates at 2^CNT_W−1.
- Rise at cycle t0 and next rise at t1 gives period = t1−t0. A fall at tf gives high = tf−t0.
- States:
  - IDLE: enable=0. cnt is held at 0. Go to ARM when enable=1.
  - ARM: waiting for the first rise. cnt counts from entry. rise → MEASURE (cnt←1, high latch cleared).
  - MEASURE:
    - fall → latch high = cnt.
    - rise → capture period = cnt and the latched high, stay in MEASURE, cnt←1.
    - If no fall was seen since the previous rise, high is captured as 0.
- Capture into the output register:
  - If meas_valid=0, or meas_valid && meas_ready in the same cycle: load the new pair and set meas_valid=1.
  - Otherwise discard the new pair, set overrun=1, and leave the outputs unchanged.
- meas_valid clears on a handshake with no simultaneous capture.
- Timeout: in ARM or MEASURE, when cnt reaches TIMEOUT with no rise in that cycle:
  - set timeout=1;
  - go to ARM and restart cnt at 1;
  - any partially latched high is dropped;
  - the held output register is unaffected.
- enable=0 in any state:
  - next cycle go to IDLE;
  - meas_valid, timeout and overrun clear;
  - data outputs hold their last value.
- Rise and timeout in the same cycle: the rise wins; no timeout.
- Glitches shorter than one clock period may be missed. Pulses of ≥ 2 cycles high and ≥ 2 cycles low are always measured exactly.

## Timing
- Reset (RSTN=0, asynchronous):
  - state = IDLE, cnt = 0, synchronizers = 0;
  - meas_period = 0, meas_high = 0;
  - meas_valid = 0, timeout = 0, overrun = 0.
- Detection latency: a sig_in transition is strobed SYNC_STAGES+1 cycles after the first clock edge that samples it. Latency is common to both edges and cancels in the measurements.
- meas_valid rises 1 cycle after the rise strobe that completes a period, i.e. SYNC_STAGES+2 cycles after the sampled input rising edge.
- After reset or enable: the first valid measurement needs two rising edges.
- Back-to-back throughput: one measurement per input period, provided meas_ready is held high.
- timeout/overrun assert the cycle after their cause and stay high until enable=0 or reset.

## Test plan
- sig_in = 1 cycle high / 4 low, synchronous to clk (the CH generator pattern with FREQ_VAL=4), meas_ready=1 -> meas_period=5 and meas_high=1 every 5 cycles, starting after the second rising edge.
- 40 kHz, 50 % duty, async phase (25 µs period) -> meas_period=2500 and meas_high=1250, each exact to within ±1 cycle from sampling jitter.
- meas_ready=0 across 3 periods, then 1 -> the first pair is held unchanged and overrun=1. After the handshake meas_valid drops, and the next period's capture loads with meas_valid=1.
- TIMEOUT=1000, sig_in held low after a valid measurement -> timeout=1 1000 cycles after the last rise strobe, state ARM, no new meas_valid. On resume, the first valid needs two rises.
- RSTN pulsed low mid-MEASURE -> all outputs 0 immediately, without a clock edge. After release with enable=1, the first valid arrives after two rises.
- enable dropped mid-measurement while meas_valid=1, timeout=1 and overrun=1 -> one cycle later all three flags are 0 and the data holds. Re-enable: normal operation resumes.
